// File: rtl/clock_counter.sv
// Real-time clock counter: HH:MM:SS in BCD, advanced by a 1 Hz tick.
// Ports: CLOCK_50, reset, tick_in, set_mode, inc_min, inc_hr -> BCD digits, pm, sec_pulse, colon.
module clock_counter #(
  parameter bit HOUR_24 = 1'b1
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       tick_in,
  input  logic       set_mode,
  input  logic       inc_min,
  input  logic       inc_hr,
  output logic [3:0] h_tens,
  output logic [3:0] h_ones,
  output logic [3:0] m_tens,
  output logic [3:0] m_ones,
  output logic [3:0] s_tens,
  output logic [3:0] s_ones,
  output logic       pm,
  output logic       sec_pulse,
  output logic       colon
);

  localparam logic [7:0] HR_RST = HOUR_24 ? 8'h00 : 8'h12;

  logic [7:0] hr;
  logic [7:0] mn;
  logic [7:0] sc;
  logic       tick_d;
  logic       edge_det;
  logic       hr_flip;

  // Two-digit BCD increment with 59 -> 00 wrap.
  function automatic logic [7:0] inc60(input logic [7:0] v);
    logic [7:0] n;
    if (v == 8'h59)
      n = 8'h00;
    else if (v[3:0] == 4'd9)
      n = {v[7:4] + 4'd1, 4'd0};
    else
      n = {v[7:4], v[3:0] + 4'd1};
    return n;
  endfunction

  // 24-hour: 00..23 -> 00. 12-hour: 12,01..11,12.
  function automatic logic [7:0] inc_hour(input logic [7:0] h);
    logic [7:0] n;
    if (HOUR_24) begin
      if (h == 8'h23)
        n = 8'h00;
      else if (h[3:0] == 4'd9)
        n = {h[7:4] + 4'd1, 4'd0};
      else
        n = {h[7:4], h[3:0] + 4'd1};
    end else begin
      if (h == 8'h12)
        n = 8'h01;
      else if (h[3:0] == 4'd9)
        n = 8'h10;
      else
        n = {h[7:4], h[3:0] + 4'd1};
    end
    return n;
  endfunction

  assign edge_det = tick_in & ~tick_d;
  // AM/PM flips when the hour steps 11 -> 12.
  assign hr_flip  = (HOUR_24 == 1'b0) && (hr == 8'h11);

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      hr        <= HR_RST;
      mn        <= 8'h00;
      sc        <= 8'h00;
      pm        <= 1'b0;
      tick_d    <= 1'b0;
      sec_pulse <= 1'b0;
    end else begin
      tick_d    <= tick_in;
      sec_pulse <= 1'b0;
      if (set_mode) begin
        // Adjust: seconds parked at 00, no carries.
        sc <= 8'h00;
        if (inc_min)
          mn <= inc60(mn);
        if (inc_hr) begin
          hr <= inc_hour(hr);
          if (hr_flip)
            pm <= ~pm;
        end
      end else if (edge_det) begin
        sec_pulse <= 1'b1;
        sc        <= inc60(sc);
        if (sc == 8'h59) begin
          mn <= inc60(mn);
          if (mn == 8'h59) begin
            hr <= inc_hour(hr);
            if (hr_flip)
              pm <= ~pm;
          end
        end
      end
    end
  end

  assign h_tens = hr[7:4];
  assign h_ones = hr[3:0];
  assign m_tens = mn[7:4];
  assign m_ones = mn[3:0];
  assign s_tens = sc[7:4];
  assign s_ones = sc[3:0];
  assign colon  = tick_d;

endmodule

// File: tb/tb_clock_counter.sv
// Directed bench for clock_counter: one 24-hour and one 12-hour instance
// share stimulus; each scenario checks the instance it targets.
module tb_clock_counter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_in = 1'b0;
  logic set_mode = 1'b0;
  logic inc_min = 1'b0;
  logic inc_hr = 1'b0;

  logic [3:0] a_ht, a_ho, a_mt, a_mo, a_st, a_so;
  logic [3:0] b_ht, b_ho, b_mt, b_mo, b_st, b_so;
  logic a_pm, a_sp, a_col;
  logic b_pm, b_sp, b_col;

  int checks = 0;
  int errors = 0;

  wire [23:0] t24 = {a_ht, a_ho, a_mt, a_mo, a_st, a_so};
  wire [23:0] t12 = {b_ht, b_ho, b_mt, b_mo, b_st, b_so};

  always #5 clk = ~clk;

  clock_counter #(.HOUR_24(1'b1)) dut24 (
    .CLOCK_50(clk), .reset(reset), .tick_in(tick_in),
    .set_mode(set_mode), .inc_min(inc_min), .inc_hr(inc_hr),
    .h_tens(a_ht), .h_ones(a_ho), .m_tens(a_mt), .m_ones(a_mo),
    .s_tens(a_st), .s_ones(a_so), .pm(a_pm),
    .sec_pulse(a_sp), .colon(a_col)
  );

  clock_counter #(.HOUR_24(1'b0)) dut12 (
    .CLOCK_50(clk), .reset(reset), .tick_in(tick_in),
    .set_mode(set_mode), .inc_min(inc_min), .inc_hr(inc_hr),
    .h_tens(b_ht), .h_ones(b_ho), .m_tens(b_mt), .m_ones(b_mo),
    .s_tens(b_st), .s_ones(b_so), .pm(b_pm),
    .sec_pulse(b_sp), .colon(b_col)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick_in = 1'b0;
    set_mode = 1'b0;
    inc_min = 1'b0;
    inc_hr = 1'b0;
    step();
    step();
    reset = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      tick_in = 1'b1;
      step();
      tick_in = 1'b0;
      step();
    end
  endtask

  task automatic pulses(input int nm, input int nh);
    for (int i = 0; i < nm; i++) begin
      inc_min = 1'b1;
      step();
      inc_min = 1'b0;
    end
    for (int i = 0; i < nh; i++) begin
      inc_hr = 1'b1;
      step();
      inc_hr = 1'b0;
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (t24 !== 24'h000000) begin
      errors++;
      $display("FAIL reset24 got %h want 000000", t24);
    end
    checks++;
    if (t12 !== 24'h120000 || b_pm !== 1'b0) begin
      errors++;
      $display("FAIL reset12 got %h pm %b want 120000 pm 0", t12, b_pm);
    end
    checks++;
    if (a_sp !== 1'b0 || a_col !== 1'b0 || a_pm !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags got sp%b col%b pm%b want 000", a_sp, a_col, a_pm);
    end
  endtask

  task automatic test_count();
    do_reset();
    for (int i = 1; i <= 3; i++) begin
      tick_in = 1'b1;
      step();
      checks++;
      if (a_so !== i[3:0] || a_sp !== 1'b1 || a_col !== 1'b1) begin
        errors++;
        $display("FAIL count%0d got so %0d sp %b col %b want %0d 1 1", i, a_so, a_sp, a_col, i);
      end
      tick_in = 1'b0;
      step();
      checks++;
      if (a_so !== i[3:0] || a_sp !== 1'b0 || a_col !== 1'b0) begin
        errors++;
        $display("FAIL count_hold%0d got so %0d sp %b col %b want %0d 0 0", i, a_so, a_sp, a_col, i);
      end
    end
  endtask

  task automatic test_edge_after_reset();
    reset = 1'b1;
    tick_in = 1'b1;
    step();
    checks++;
    if (t24 !== 24'h000000 || a_col !== 1'b0) begin
      errors++;
      $display("FAIL rst_tick got %h col %b want 000000 0", t24, a_col);
    end
    reset = 1'b0;
    step();
    checks++;
    if (t24 !== 24'h000001 || a_sp !== 1'b1) begin
      errors++;
      $display("FAIL first_edge got %h sp %b want 000001 1", t24, a_sp);
    end
    tick_in = 1'b0;
    step();
  endtask

  task automatic test_wrap24();
    do_reset();
    set_mode = 1'b1;
    pulses(59, 23);
    checks++;
    if (t24 !== 24'h235900) begin
      errors++;
      $display("FAIL preload24 got %h want 235900", t24);
    end
    set_mode = 1'b0;
    ticks(58);
    checks++;
    if (t24 !== 24'h235958) begin
      errors++;
      $display("FAIL at58 got %h want 235958", t24);
    end
    ticks(1);
    checks++;
    if (t24 !== 24'h235959) begin
      errors++;
      $display("FAIL at59 got %h want 235959", t24);
    end
    tick_in = 1'b1;
    step();
    checks++;
    if (t24 !== 24'h000000 || a_sp !== 1'b1) begin
      errors++;
      $display("FAIL wrap24 got %h sp %b want 000000 1", t24, a_sp);
    end
    tick_in = 1'b0;
    step();
  endtask

  task automatic test_wrap12();
    do_reset();
    set_mode = 1'b1;
    pulses(59, 11);
    set_mode = 1'b0;
    ticks(59);
    checks++;
    if (t12 !== 24'h115959 || b_pm !== 1'b0) begin
      errors++;
      $display("FAIL am1159 got %h pm %b want 115959 0", t12, b_pm);
    end
    ticks(1);
    checks++;
    if (t12 !== 24'h120000 || b_pm !== 1'b1) begin
      errors++;
      $display("FAIL noon got %h pm %b want 120000 1", t12, b_pm);
    end
    ticks(5);
    set_mode = 1'b1;
    step();
    checks++;
    if (t12 !== 24'h120000) begin
      errors++;
      $display("FAIL sec_force got %h want 120000", t12);
    end
    pulses(59, 0);
    set_mode = 1'b0;
    ticks(59);
    checks++;
    if (t12 !== 24'h125959 || b_pm !== 1'b1) begin
      errors++;
      $display("FAIL pm1259 got %h pm %b want 125959 1", t12, b_pm);
    end
    ticks(1);
    checks++;
    if (t12 !== 24'h010000 || b_pm !== 1'b1) begin
      errors++;
      $display("FAIL pm0100 got %h pm %b want 010000 1", t12, b_pm);
    end
  endtask

  task automatic test_adjust();
    do_reset();
    set_mode = 1'b1;
    pulses(59, 10);
    set_mode = 1'b0;
    ticks(5);
    checks++;
    if (t24 !== 24'h105905) begin
      errors++;
      $display("FAIL adj_pre got %h want 105905", t24);
    end
    set_mode = 1'b1;
    tick_in = 1'b1;
    inc_min = 1'b1;
    inc_hr = 1'b1;
    step();
    inc_min = 1'b0;
    inc_hr = 1'b0;
    checks++;
    if (t24 !== 24'h110000 || a_sp !== 1'b0) begin
      errors++;
      $display("FAIL adj_both got %h sp %b want 110000 0", t24, a_sp);
    end
    checks++;
    if (t12 !== 24'h110000 || b_pm !== 1'b0) begin
      errors++;
      $display("FAIL adj_both12 got %h pm %b want 110000 0", t12, b_pm);
    end
    tick_in = 1'b0;
    step();
    set_mode = 1'b0;
    step();
    step();
    checks++;
    if (t24 !== 24'h110000 || a_sp !== 1'b0) begin
      errors++;
      $display("FAIL resume_idle got %h sp %b want 110000 0", t24, a_sp);
    end
    ticks(1);
    checks++;
    if (t24 !== 24'h110001) begin
      errors++;
      $display("FAIL resume got %h want 110001", t24);
    end
  endtask

  task automatic test_ignore_inc();
    do_reset();
    pulses(3, 3);
    checks++;
    if (t24 !== 24'h000000) begin
      errors++;
      $display("FAIL ign_inc got %h want 000000", t24);
    end
    tick_in = 1'b1;
    inc_min = 1'b1;
    inc_hr = 1'b1;
    step();
    inc_min = 1'b0;
    inc_hr = 1'b0;
    checks++;
    if (t24 !== 24'h000001 || a_sp !== 1'b1) begin
      errors++;
      $display("FAIL ign_tick got %h sp %b want 000001 1", t24, a_sp);
    end
    tick_in = 1'b0;
    step();
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_mode = 1'b1;
    pulses(42, 5);
    set_mode = 1'b0;
    ticks(17);
    checks++;
    if (t24 !== 24'h054217) begin
      errors++;
      $display("FAIL mid_pre got %h want 054217", t24);
    end
    reset = 1'b1;
    tick_in = 1'b1;
    step();
    checks++;
    if (t24 !== 24'h000000 || a_sp !== 1'b0) begin
      errors++;
      $display("FAIL mid_rst got %h sp %b want 000000 0", t24, a_sp);
    end
    reset = 1'b0;
    tick_in = 1'b0;
    step();
    checks++;
    if (t24 !== 24'h000000 || a_sp !== 1'b0) begin
      errors++;
      $display("FAIL mid_after got %h sp %b want 000000 0", t24, a_sp);
    end
  endtask

  initial begin
    test_reset();
    test_count();
    test_edge_after_reset();
    test_wrap24();
    test_wrap12();
    test_adjust();
    test_ignore_inc();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
